// File: rtl/intr_ctrl.sv
// Priority interrupt controller: latches irq rising edges into PENDING, applies
// MASK and in-service nesting, raises int_out to the CPU and supplies the
// winning source index as the vector word during the CPU's intack cycle.
// MASK / PENDING / EOI / STATUS live in a 4-word memory-mapped window.
module intr_ctrl #(
  parameter int          N_SRC     = 4,
  parameter logic [11:0] BASE_ADDR = 12'hA00,
  parameter logic [15:0] SPUR_VEC  = 16'h0007
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  output logic             int_out,
  input  logic             intack,
  output logic [15:0]      vec_out,
  input  logic [11:0]      bus_addr,
  input  logic [15:0]      bus_wdata,
  input  logic             bus_we,
  output logic [15:0]      bus_rdata,
  output logic             bus_hit
);

  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [N_SRC-1:0] ONE_N = N_SRC'(1);

  // Register offsets inside the window
  localparam logic [1:0] OFS_MASK   = 2'd0;
  localparam logic [1:0] OFS_PEND   = 2'd1;
  localparam logic [1:0] OFS_EOI    = 2'd2;
  localparam logic [1:0] OFS_STATUS = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [N_SRC-1:0] mask_reg, mask_next;
  logic [N_SRC-1:0] pending_reg, pending_next;
  logic [N_SRC-1:0] in_service_reg, in_service_next;
  logic [N_SRC-1:0] irq_q_reg;
  logic [GW-1:0]    grant_reg, grant_next;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] above;
  logic [N_SRC-1:0] eligible;
  logic [GW-1:0]    winner;

  logic [11:0]      offset;
  logic [1:0]       reg_sel;
  logic             wr_mask, wr_pend, wr_eoi;

  logic [15:0]      mask_ext, pend_ext;
  logic [7:0]       isr_ext;

  // Upper data bits beyond the source count carry no register state.
  logic             unused_wdata;
  assign unused_wdata = ^bus_wdata[15:N_SRC];

  // Only a 0->1 transition of an irq line raises a request.
  assign rise = irq & ~irq_q_reg;

  // A source may interrupt only if every in-service bit at or above its
  // priority (index <= its own) is clear; with nothing in service all pass.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_above
      assign above[gi] = ~|in_service_reg[gi:0];
    end
  endgenerate

  assign eligible = pending_reg & mask_reg & above;

  // Fixed-priority encoder: lowest eligible index wins.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = GW'(i);
    end
  end

  // Window decode; unsigned wrap of the subtraction rejects addresses below the base.
  assign offset  = bus_addr - BASE_ADDR;
  assign bus_hit = (offset < 12'd4);
  assign reg_sel = offset[1:0];
  assign wr_mask = bus_we && bus_hit && (reg_sel == OFS_MASK);
  assign wr_pend = bus_we && bus_hit && (reg_sel == OFS_PEND);
  assign wr_eoi  = bus_we && bus_hit && (reg_sel == OFS_EOI);

  // Next-state, grant and register updates; edge-set is applied last so a new
  // request survives a same-cycle W1C or acknowledge clear.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    mask_next       = wr_mask ? bus_wdata[N_SRC-1:0] : mask_reg;
    pending_next    = pending_reg;
    in_service_next = in_service_reg;

    if (wr_pend) pending_next = pending_next & ~bus_wdata[N_SRC-1:0];

    // EOI retires the highest-priority (lowest-index) in-service source,
    // evaluated on the old in_service before any acknowledge sets a bit.
    if (wr_eoi) in_service_next = in_service_reg & (in_service_reg - ONE_N);

    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          grant_next = winner;
          state_next = REQ;
        end
      end
      REQ: begin
        if (intack) begin
          // grant_reg is held through the acknowledge cycle
          pending_next[grant_reg]    = 1'b0;
          in_service_next[grant_reg] = 1'b1;
          state_next                 = IDLE;
        end else if (|eligible) begin
          grant_next = winner;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    pending_next = pending_next | rise;
  end

  // State and register file update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      mask_reg       <= '0;
      pending_reg    <= '0;
      in_service_reg <= '0;
      irq_q_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      mask_reg       <= mask_next;
      pending_reg    <= pending_next;
      in_service_reg <= in_service_next;
      irq_q_reg      <= irq;
    end
  end

  assign int_out = (state_reg == REQ);

  // Vector word: granted index while requesting, otherwise the spurious vector.
  always_comb begin
    vec_out = SPUR_VEC;
    if (state_reg == REQ) begin
      vec_out           = '0;
      vec_out[GW-1:0]   = grant_reg;
    end
  end

  // Zero-extend register fields to the bus width.
  always_comb begin
    mask_ext               = '0;
    pend_ext               = '0;
    isr_ext                = '0;
    mask_ext[N_SRC-1:0]    = mask_reg;
    pend_ext[N_SRC-1:0]    = pending_reg;
    isr_ext[N_SRC-1:0]     = in_service_reg;
  end

  // Combinational register read mux; EOI and out-of-window addresses read zero.
  always_comb begin
    bus_rdata = '0;
    if (bus_hit) begin
      case (reg_sel)
        OFS_MASK:   bus_rdata = mask_ext;
        OFS_PEND:   bus_rdata = pend_ext;
        OFS_EOI:    bus_rdata = '0;
        OFS_STATUS: bus_rdata = {isr_ext, 5'b0, (state_reg == REQ), 2'b0};
        default:    bus_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever a vector, read or int probe is presented.
module tb_intr_ctrl;

  localparam logic [11:0] BASE = 12'hA00;
  localparam int K_VEC = 0;
  localparam int K_RD  = 1;
  localparam int K_INT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  irq = '0;
  logic        int_out;
  logic        intack = 1'b0;
  logic [15:0] vec_out;
  logic [11:0] bus_addr = '0;
  logic [15:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic [15:0] bus_rdata;
  logic        bus_hit;

  logic rd_strobe  = 1'b0;
  logic int_strobe = 1'b0;

  typedef struct {
    int          kind;
    logic [16:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  intr_ctrl #(.N_SRC(4), .BASE_ADDR(12'hA00), .SPUR_VEC(16'h0007)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .int_out   (int_out),
    .intack    (intack),
    .vec_out   (vec_out),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .bus_hit   (bus_hit)
  );

  always #5 clk = ~clk;

  task automatic check_one(input int kind, input logic [16:0] act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL no_expectation kind=%0d actual=%h", kind, act);
      return;
    end
    e = sb.pop_front();
    if (e.kind != kind || act !== e.exp)
      $display("FAIL %s: actual=%h required=%h (kind %0d/%0d)", e.name, act, e.exp, kind, e.kind);
    else begin
      passed++;
      $display("ok   %s: %h", e.name, act);
    end
  endtask

  // Monitor: compare whatever the DUT presents this cycle against the queue head.
  always @(negedge clk) begin
    if (intack)     check_one(K_VEC, {1'b0, vec_out});
    if (rd_strobe)  check_one(K_RD,  {bus_hit, bus_rdata});
    if (int_strobe) check_one(K_INT, {16'b0, int_out});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [16:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [15:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] addr, input logic [16:0] exp, input string name);
    push(K_RD, exp, name);
    bus_addr  = addr;
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic check_int(input logic exp, input string name);
    push(K_INT, {16'b0, exp}, name);
    int_strobe = 1'b1;
    tick();
    int_strobe = 1'b0;
  endtask

  task automatic do_intack(input logic [15:0] exp, input string name);
    push(K_VEC, {1'b0, exp}, name);
    intack = 1'b1;
    tick();
    intack = 1'b0;
  endtask

  // Watchdog: the stimulus has no open-ended waits, but never hang regardless.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check_int(1'b0, "rst_int");
    do_read(BASE + 0, {1'b1, 16'h0000}, "rst_mask");
    do_read(BASE + 1, {1'b1, 16'h0000}, "rst_pend");
    do_read(BASE + 2, {1'b1, 16'h0000}, "rst_eoi");
    do_read(BASE + 3, {1'b1, 16'h0000}, "rst_status");
    do_read(12'h9FF,  {1'b0, 16'h0000}, "outside_window");
    do_intack(16'h0007, "rst_spurious");

    // Single source, two-cycle latency, acknowledge
    do_write(BASE + 0, 16'h0002);
    irq = 4'b0010;
    check_int(1'b0, "t1_int_c0");
    check_int(1'b0, "t1_int_c1");
    check_int(1'b1, "t1_int_c2");
    irq = 4'b0000;
    do_intack(16'h0001, "t1_vec");
    check_int(1'b0, "t1_int_after_ack");
    do_read(BASE + 1, {1'b1, 16'h0000}, "t1_pend");
    do_read(BASE + 3, {1'b1, 16'h0200}, "t1_status");
    do_write(BASE + 2, 16'h0000);
    do_read(BASE + 3, {1'b1, 16'h0000}, "t1_status_eoi");

    // Simultaneous 3 and 1: nesting blocks 3 until EOI
    do_write(BASE + 0, 16'h000F);
    irq = 4'b1010;
    tick(); tick(); tick();
    do_intack(16'h0001, "t2_vec1");
    check_int(1'b0, "t2_blocked_a");
    check_int(1'b0, "t2_blocked_b");
    check_int(1'b0, "t2_blocked_c");
    do_intack(16'h0007, "t2_spurious_idle");
    do_read(BASE + 3, {1'b1, 16'h0200}, "t2_status");
    do_read(BASE + 1, {1'b1, 16'h0008}, "t2_pend");
    do_write(BASE + 2, 16'h0000);
    check_int(1'b0, "t2_int_after_eoi");
    check_int(1'b1, "t2_int_reassert");
    do_intack(16'h0003, "t2_vec3");
    do_write(BASE + 2, 16'h0000);
    irq = 4'b0000;
    tick();

    // Preemption in REQ: grant 2 replaced by 0
    irq = 4'b0100;
    tick(); tick();
    do_read(BASE + 3, {1'b1, 16'h0004}, "t3_status_req");
    irq = 4'b0101;
    tick(); tick();
    do_intack(16'h0000, "t3_vec_preempt");
    do_read(BASE + 1, {1'b1, 16'h0004}, "t3_pend2_kept");
    do_write(BASE + 1, 16'h0004);
    do_write(BASE + 2, 16'h0000);
    irq = 4'b0000;
    tick();

    // Mask cleared while requesting
    irq = 4'b1000;
    tick(); tick();
    check_int(1'b1, "t4_int_req");
    do_write(BASE + 0, 16'h0000);
    check_int(1'b1, "t4_int_same");
    check_int(1'b0, "t4_int_fell");
    do_intack(16'h0007, "t4_spurious");
    do_read(BASE + 0, {1'b1, 16'h0000}, "t4_mask");
    do_read(BASE + 1, {1'b1, 16'h0008}, "t4_pend");
    do_read(BASE + 3, {1'b1, 16'h0000}, "t4_status");
    do_write(BASE + 1, 16'h0008);
    do_write(BASE + 0, 16'h000F);
    irq = 4'b0000;
    tick();

    // Rising edge vs W1C in the same cycle: set wins
    irq = 4'b0010;
    do_write(BASE + 1, 16'h0002);
    do_read(BASE + 1, {1'b1, 16'h0002}, "t5_pend_set_wins");
    do_intack(16'h0001, "t5_vec");
    do_write(BASE + 2, 16'h0000);
    irq = 4'b0000;
    tick();

    // EOI and acknowledge in the same cycle
    irq = 4'b0010;
    tick(); tick();
    do_intack(16'h0001, "t7_vec1");
    irq = 4'b0011;
    tick(); tick();
    push(K_VEC, {1'b0, 16'h0000}, "t7_vec0_with_eoi");
    bus_addr = BASE + 2;
    bus_we   = 1'b1;
    intack   = 1'b1;
    tick();
    bus_we   = 1'b0;
    intack   = 1'b0;
    do_read(BASE + 3, {1'b1, 16'h0100}, "t7_status");
    do_write(BASE + 2, 16'h0000);
    irq = 4'b0000;
    tick();

    // Reset while requesting
    irq = 4'b0101;
    tick(); tick();
    do_read(BASE + 1, {1'b1, 16'h0005}, "t6_pend_before");
    irq = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_int(1'b0, "t6_int_after_rst");
    do_read(BASE + 0, {1'b1, 16'h0000}, "t6_mask");
    do_read(BASE + 1, {1'b1, 16'h0000}, "t6_pend");
    do_read(BASE + 3, {1'b1, 16'h0000}, "t6_status");

    // Drain any outstanding expectations with a bounded wait
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      $display("FAIL %s: actual=never_presented required=%h", e.name, e.exp);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
